// File: rtl/shift_sequencer_if.sv
// Shared MICRO-1 shifter types and the datapath-facing request/response bundle
// of the multi-bit shift sequencer.
package shift_sequencer_pkg;
  localparam int unsigned WORD_WIDTH = 16;

  typedef logic [WORD_WIDTH-1:0] micro1_machine_word_t;

  typedef enum logic [2:0] {
    NOP                  = 3'd0,
    LEFT_LOGICALLY       = 3'd1,
    RIGHT_LOGICALLY      = 3'd2,
    LEFT_ARITHMETICALLY  = 3'd3,
    RIGHT_ARITHMETICALLY = 3'd4,
    EXTENSION            = 3'd5,
    SWAP                 = 3'd6
  } shifter_operation_t;
endpackage

interface shift_sequencer_if
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 4
) ();
  logic                   start;
  shifter_operation_t     operation;
  logic [COUNT_WIDTH-1:0] count;
  logic                   rotate;
  logic                   fill;
  micro1_machine_word_t   operand;
  logic                   busy;
  logic                   done;
  micro1_machine_word_t   result;
  logic                   carry;

  modport master (
    output start, operation, count, rotate, fill, operand,
    input  busy, done, result, carry
  );

  modport slave (
    input  start, operation, count, rotate, fill, operand,
    output busy, done, result, carry
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-bit shift/rotate controller: steps the single-bit MICRO-1 shifter once
// per clock, feeding its output back, and returns the final word and carry.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_sequencer_if.slave     bus,
  output shifter_operation_t   sh_operation,
  output micro1_machine_word_t sh_in,
  output logic                 sh_cin,
  input  micro1_machine_word_t sh_out,
  input  logic                 sh_cout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  shifter_operation_t     op_q, op_d;
  logic                   rotate_q, rotate_d;
  logic                   fill_q, fill_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  micro1_machine_word_t   result_q, result_d;
  logic                   carry_q, carry_d;
  shifter_operation_t     sh_operation_q, sh_operation_d;
  micro1_machine_word_t   sh_in_q, sh_in_d;
  logic                   sh_cin_q, sh_cin_d;
  micro1_machine_word_t   word_d;
  logic [COUNT_WIDTH-1:0] steps_c;

  // Rotates recirculate the bit about to fall off; everything else takes the fill bit.
  function automatic logic cin_sel(input shifter_operation_t op, input logic rot,
                                   input logic fil, input micro1_machine_word_t w);
    logic c;
    c = fil;
    if (rot && op == LEFT_LOGICALLY)  c = w[WORD_WIDTH-1];
    if (rot && op == RIGHT_LOGICALLY) c = w[0];
    return c;
  endfunction

  // Only true shifts honour count; the byte ops are a single shifter pass.
  always_comb begin
    steps_c = COUNT_WIDTH'(1);
    case (bus.operation)
      LEFT_LOGICALLY, RIGHT_LOGICALLY,
      LEFT_ARITHMETICALLY, RIGHT_ARITHMETICALLY: steps_c = COUNT_WIDTH'(bus.count);
      default:                                   steps_c = COUNT_WIDTH'(1);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rotate_d = rotate_q;
    fill_d   = fill_q;
    rem_d    = rem_q;
    result_d = result_q;
    carry_d  = carry_q;
    word_d   = sh_in_q;

    case (state_q)
      SHIFT: begin
        word_d = sh_out;
        rem_d  = rem_q - COUNT_WIDTH'(1);
        if (rem_q == COUNT_WIDTH'(1)) begin
          state_d  = DONE;
          result_d = sh_out;
          carry_d  = sh_cout;
        end
      end
      default: begin
        state_d = IDLE;
        if (bus.start) begin
          op_d     = bus.operation;
          rotate_d = bus.rotate;
          fill_d   = bus.fill;
          word_d   = bus.operand;
          rem_d    = steps_c;
          if (steps_c == '0) begin
            state_d  = DONE;
            result_d = bus.operand;
            carry_d  = 1'b0;
          end else begin
            state_d = SHIFT;
          end
        end
      end
    endcase

    // Shifter drive is precomputed so it is valid from the first SHIFT cycle.
    busy_d         = (state_d == SHIFT);
    done_d         = (state_d == DONE);
    sh_operation_d = busy_d ? op_d : NOP;
    sh_in_d        = busy_d ? word_d : '0;
    sh_cin_d       = busy_d ? cin_sel(op_d, rotate_d, fill_d, word_d) : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      op_q           <= NOP;
      rotate_q       <= 1'b0;
      fill_q         <= 1'b0;
      rem_q          <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      result_q       <= '0;
      carry_q        <= 1'b0;
      sh_operation_q <= NOP;
      sh_in_q        <= '0;
      sh_cin_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      rotate_q       <= rotate_d;
      fill_q         <= fill_d;
      rem_q          <= rem_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      result_q       <= result_d;
      carry_q        <= carry_d;
      sh_operation_q <= sh_operation_d;
      sh_in_q        <= sh_in_d;
      sh_cin_q       <= sh_cin_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.carry    = carry_q;
  assign sh_operation = sh_operation_q;
  assign sh_in        = sh_in_q;
  assign sh_cin       = sh_cin_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer wired to a behavioural single-step MICRO-1 shifter;
// expected words come from closed-form shift/rotate arithmetic.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  localparam int unsigned COUNT_WIDTH = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  shifter_operation_t   sh_operation;
  micro1_machine_word_t sh_in, sh_out;
  logic                 sh_cin, sh_cout;

  shift_sequencer_if #(.COUNT_WIDTH(COUNT_WIDTH)) bus ();

  shift_sequencer #(.COUNT_WIDTH(COUNT_WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .sh_operation (sh_operation),
    .sh_in        (sh_in),
    .sh_cin       (sh_cin),
    .sh_out       (sh_out),
    .sh_cout      (sh_cout)
  );

  always #5 clk = ~clk;

  // Stand-in for the real one-bit shifter.
  always_comb begin
    sh_out  = sh_in;
    sh_cout = 1'b0;
    case (sh_operation)
      LEFT_LOGICALLY, LEFT_ARITHMETICALLY: begin
        sh_out = {sh_in[14:0], sh_cin}; sh_cout = sh_in[15];
      end
      RIGHT_LOGICALLY: begin
        sh_out = {sh_cin, sh_in[15:1]}; sh_cout = sh_in[0];
      end
      RIGHT_ARITHMETICALLY: begin
        sh_out = {sh_in[15], sh_in[15:1]}; sh_cout = sh_in[0];
      end
      EXTENSION: sh_out = {{8{sh_in[7]}}, sh_in[7:0]};
      SWAP:      sh_out = {sh_in[7:0], sh_in[15:8]};
      default:   sh_out = sh_in;
    endcase
  end

  typedef struct {
    micro1_machine_word_t result;
    logic                 carry;
    shifter_operation_t   op;
    int                   acc;
    int                   edge_n;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  function automatic void ref_model(input shifter_operation_t op, input int n,
                                    input logic rot, input logic fil,
                                    input micro1_machine_word_t x,
                                    output micro1_machine_word_t res, output logic c,
                                    output int steps);
    logic [31:0] w;
    w     = {16'h0, x};
    res   = x;
    c     = 1'b0;
    steps = 1;
    case (op)
      LEFT_LOGICALLY, LEFT_ARITHMETICALLY: begin
        steps = n;
        if (n > 0) begin
          c = x[16-n];
          if (rot && op == LEFT_LOGICALLY) res = 16'((w << n) | (w >> (16 - n)));
          else res = 16'((w << n) | (fil ? ((32'd1 << n) - 32'd1) : 32'd0));
        end
      end
      RIGHT_LOGICALLY: begin
        steps = n;
        if (n > 0) begin
          c = x[n-1];
          if (rot) res = 16'((w >> n) | (w << (16 - n)));
          else res = 16'((w >> n) | (fil ? (32'hFFFF << (16 - n)) : 32'd0));
        end
      end
      RIGHT_ARITHMETICALLY: begin
        steps = n;
        if (n > 0) begin
          c   = x[n-1];
          res = 16'($signed(x) >>> n);
        end
      end
      EXTENSION: res = {{8{x[7]}}, x[7:0]};
      SWAP:      res = {x[7:0], x[15:8]};
      default:   res = x;
    endcase
  endfunction

  // Caller sits at a falling edge; the request is accepted at the next rising edge.
  task automatic issue(input shifter_operation_t op, input int n, input logic rot,
                       input logic fil, input micro1_machine_word_t x,
                       input logic use_exp, input micro1_machine_word_t er, input logic ec);
    micro1_machine_word_t res;
    logic c;
    int steps;
    int w = 0;
    exp_t e;
    while (bus.busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("busy_wait_timeout", 32'd1, 32'd0);
    ref_model(op, n, rot, fil, x, res, c, steps);
    if (use_exp) begin
      res = er;
      c   = ec;
    end
    bus.operation = op;
    bus.count     = COUNT_WIDTH'(n);
    bus.rotate    = rot;
    bus.fill      = fil;
    bus.operand   = x;
    bus.start     = 1'b1;
    e.result = res;
    e.carry  = c;
    e.op     = op;
    e.acc    = cyc + 1;
    e.edge_n = cyc + 1 + steps;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Monitor: tracks busy/shifter drive every cycle and scores each done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_busy;
      exp_busy = (sb.size() > 0) && (cyc >= sb[0].acc) && (cyc < sb[0].edge_n);
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      if (exp_busy) chk("sh_operation", 32'(sh_operation), 32'(sb[0].op));
      else begin
        chk("sh_operation_idle", 32'(sh_operation), 32'(NOP));
        chk("sh_cin_idle", 32'(sh_cin), 32'd0);
      end
      if (bus.done) begin
        if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          chk("done_cycle", 32'(cyc), 32'(sb[0].edge_n));
          chk("result", 32'(bus.result), 32'(sb[0].result));
          chk("carry", 32'(bus.carry), 32'(sb[0].carry));
          void'(sb.pop_front());
        end
      end else if (sb.size() > 0 && cyc > sb[0].edge_n) begin
        chk("done_missing", 32'(cyc), 32'(sb[0].edge_n));
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    int wait_n;
    bus.start     = 1'b0;
    bus.operation = NOP;
    bus.count     = '0;
    bus.rotate    = 1'b0;
    bus.fill      = 1'b0;
    bus.operand   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_carry", 32'(bus.carry), 32'd0);
    chk("rst_sh_operation", 32'(sh_operation), 32'(NOP));
    rst_n = 1'b1;
    @(negedge clk);

    issue(LEFT_LOGICALLY, 4, 1'b0, 1'b0, 16'hA5A5, 1'b1, 16'h5A50, 1'b0);
    issue(RIGHT_LOGICALLY, 4, 1'b1, 1'b0, 16'h0128, 1'b1, 16'h8012, 1'b1);
    issue(LEFT_LOGICALLY, 0, 1'b0, 1'b0, 16'h1234, 1'b1, 16'h1234, 1'b0);
    issue(SWAP, 7, 1'b0, 1'b0, 16'h0123, 1'b1, 16'h2301, 1'b0);

    // Start pulse while busy must be ignored.
    issue(LEFT_LOGICALLY, 8, 1'b0, 1'b0, 16'h00FF, 1'b1, 16'hFF00, 1'b0);
    @(negedge clk);
    bus.operand = 16'hFFFF;
    bus.count   = COUNT_WIDTH'(3);
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;

    // Reset mid-operation aborts with no done pulse.
    issue(LEFT_LOGICALLY, 10, 1'b0, 1'b0, 16'h0F0F, 1'b0, 16'h0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_result", 32'(bus.result), 32'd0);
    chk("abort_carry", 32'(bus.carry), 32'd0);
    chk("abort_sh_operation", 32'(sh_operation), 32'(NOP));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(SWAP, 0, 1'b0, 1'b0, 16'hABCD, 1'b1, 16'hCDAB, 1'b0);

    // Boundary shifts and fill-bit coverage.
    issue(LEFT_LOGICALLY, 15, 1'b0, 1'b1, 16'h8001, 1'b0, 16'h0, 1'b0);
    issue(RIGHT_ARITHMETICALLY, 15, 1'b0, 1'b0, 16'h8000, 1'b0, 16'h0, 1'b0);
    issue(EXTENSION, 3, 1'b0, 1'b0, 16'h1280, 1'b0, 16'h0, 1'b0);

    for (int i = 0; i < 80; i++) begin
      shifter_operation_t op;
      int n;
      op = shifter_operation_t'($urandom_range(0, 6));
      n  = int'($urandom_range(0, 15));
      issue(op, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            16'($urandom), 1'b0, 16'h0, 1'b0);
      if (bus.busy && ($urandom_range(0, 3) == 0)) begin
        bus.operand   = 16'($urandom);
        bus.operation = shifter_operation_t'($urandom_range(0, 6));
        bus.count     = COUNT_WIDTH'($urandom_range(0, 15));
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    wait_n = 0;
    while (sb.size() > 0 && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    if (sb.size() > 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-bit shift controller placed directly upstream of the single-step MICRO-1 shifter.
- Accepts a 16-bit operand, an operation and a shift count, then drives the combinational shifter once per clock.
- Feeds the shifter output back into its own data register and returns the final word and carry to the datapath with a done pulse.
- Gives the microprogram N-bit shifts and rotates from the existing one-bit shifter.

Parameters:
- COUNT_WIDTH, 4, width of shift count; max count 2**COUNT_WIDTH-1 = 15.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only when busy=0.
- operation  in  SHIFTER_OPERATION  operation for the request.
- count  in  COUNT_WIDTH  number of shifter steps.
- rotate  in  1  1 = rotate; LEFT/RIGHT_LOGICALLY only.
- fill  in  1  fill bit fed to shifter cin when not rotating.
- operand  in  MICRO1_MACHINE_WORD (16)  input word.
- busy  out  1  high while stepping.
- done  out  1  one-cycle pulse, result/carry valid.
- result  out  16  final word, held until next accepted start.
- carry  out  1  shifter cout of last step, held.
- sh_operation  out  SHIFTER_OPERATION  to shifter.
- sh_in  out  16  to shifter in.
- sh_cin  out  1  to shifter cin.
- sh_out  in  16  from shifter out.
- sh_cout  in  1  from shifter cout.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, result=16'h0000, carry=0.
  - remaining=0; sh_operation=NOP, sh_in=0, sh_cin=0.
  - Reset asserted mid-operation aborts immediately; no done pulse.
- States IDLE, SHIFT, DONE.
- Accept: start=1 while busy=0 (state IDLE or DONE).
  - Latch operand into data reg, operation into op reg, rotate and fill.
  - Clear carry.
  - Step count: op LEFT/RIGHT_LOGICALLY/ARITHMETICALLY uses steps=count; op EXTENSION/SWAP/NOP uses steps=1, count ignored.
  - steps=0: go to DONE. result=operand, carry=0, shifter not driven.
  - Otherwise: go to SHIFT with remaining=steps.
- SHIFT, per cycle:
  - sh_operation=op, sh_in=data reg.
  - sh_cin = rotate ? (LEFT_LOGICALLY ? data[15] : RIGHT_LOGICALLY ? data[0] : fill) : fill.
  - Edge: data<=sh_out, carry<=sh_cout, remaining<=remaining-1.
  - remaining==1 at edge: go to DONE.
  - busy=1 throughout.
- DONE:
  - done=1 for exactly one cycle; result=data reg.
  - Then IDLE, unless start=1, which is accepted and goes to SHIFT/DONE per the rules above.
- Latency: start sampled at edge 0; done is high in cycle steps+1 (count=0 → cycle 1).
- start while busy=1 is ignored: no effect on data, count or result.
- sh_operation=NOP and sh_cin=0 in IDLE and DONE.
- result/carry change only on entry to DONE or on reset.

Test Plan (sequencer wired to the real shifter):
- SLL, operand 16'hA5A5, count 4, fill 0, rotate 0 → done in cycle 5, result 16'h5A50, carry 0, busy high cycles 1–4.
- RIGHT_LOGICALLY rotate=1, operand 16'h0128, count 4 → result 16'h8012, carry 1, done in cycle 5.
- SLL count 0, operand 16'h1234 → done in cycle 1, result 16'h1234, carry 0, sh_operation stays NOP throughout.
- SWAP count 7, operand 16'h0123 → exactly one step, done in cycle 2, result 16'h2301, carry 0.
- SLL count 8, operand 16'h00FF; second start pulse in cycle 3 with operand 16'hFFFF → ignored, done in cycle 9, result 16'hFF00, carry 0.
- SLL count 10 started, rst_n low during cycle 4 → busy=0, done=0, result 16'h0000, carry 0 immediately; after release, new SWAP request on 16'hABCD → result 16'hCDAB.
